// File: rtl/eth_frame_recv.sv
// eth_frame_recv
// Receive side of the local-link loopback. Parses the 14-byte Ethernet header
// (destination MAC, source MAC, EtherType), then packs the payload bytes into
// 32-bit words with the first byte in [7:0]. Reports status for every frame
// and keeps saturating counts of good and dropped frames.
//
// Ports:
//   clk, rst                  local-link clock, synchronous active-high reset
//   rx_en                     enable, registered onto rx_dst_rdy
//   rx_data, rx_sof, rx_eof,
//   rx_src_rdy, rx_dst_rdy    local-link byte sink
//   word_out, word_valid,
//   word_bytes                packed payload words (1-4 valid bytes)
//   src_mac                   source MAC of the last frame that passed the header checks
//   frame_done, frame_good,
//   pay_len                   per-frame strobe, held status and payload length
//   frame_cnt, drop_cnt       saturating good / dropped frame counters
//
// state | meaning
// IDLE  | waiting for a start-of-frame beat
// HEAD  | receiving header bytes 1..13
// DATA  | packing payload bytes into words
// DROP  | discarding bytes until eof (bad header or truncated)

module eth_frame_recv #(
    parameter logic [47:0] MAC_ADDR    = 48'hda0203040506,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int          MAX_PAYLOAD = 1420,
    parameter bit          CHECK_MAC   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_src_rdy,
    output logic        rx_dst_rdy,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic [2:0]  word_bytes,
    output logic [47:0] src_mac,
    output logic        frame_done,
    output logic        frame_good,
    output logic [10:0] pay_len,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, DROP} state_t;

    localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD);

    state_t      state_q, state_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic        err_q, err_d;
    logic        trunc_q, trunc_d;
    logic [47:0] shadow_q, shadow_d;
    logic [10:0] pay_cnt_q, pay_cnt_d;
    logic [31:0] lanes_q, lanes_d;
    logic        rx_dst_rdy_q, rx_dst_rdy_d;
    logic [31:0] word_out_q, word_out_d;
    logic        word_valid_q, word_valid_d;
    logic [2:0]  word_bytes_q, word_bytes_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_good_q, frame_good_d;
    logic [10:0] pay_len_q, pay_len_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        beat;
    logic [3:0]  byte_idx;
    logic [7:0]  exp_byte;
    logic        chk_byte;
    logic        byte_bad;
    logic [1:0]  lane;
    logic [31:0] lanes_wr;
    logic [10:0] pay_next;
    logic [10:0] drop_len;
    logic [1:0]  drop_inc;
    logic        frame_inc;
    logic [16:0] drop_sum;

    assign beat     = rx_src_rdy & rx_dst_rdy_q;
    // a start-of-frame byte is always header byte 0, even when it aborts a frame
    assign byte_idx = rx_sof ? 4'd0 : hdr_cnt_q;
    assign lane     = pay_cnt_q[1:0];
    assign pay_next = pay_cnt_q + 11'd1;
    // bytes already handed out as words; nothing when the header failed
    assign drop_len = (state_q == DATA || (state_q == DROP && trunc_q)) ? pay_cnt_q : 11'd0;

    always_comb begin
        exp_byte = 8'h00;
        chk_byte = 1'b0;
        case (byte_idx)
            4'd0:  begin exp_byte = MAC_ADDR[47:40];  chk_byte = CHECK_MAC; end
            4'd1:  begin exp_byte = MAC_ADDR[39:32];  chk_byte = CHECK_MAC; end
            4'd2:  begin exp_byte = MAC_ADDR[31:24];  chk_byte = CHECK_MAC; end
            4'd3:  begin exp_byte = MAC_ADDR[23:16];  chk_byte = CHECK_MAC; end
            4'd4:  begin exp_byte = MAC_ADDR[15:8];   chk_byte = CHECK_MAC; end
            4'd5:  begin exp_byte = MAC_ADDR[7:0];    chk_byte = CHECK_MAC; end
            4'd12: begin exp_byte = ETHERTYPE[15:8];  chk_byte = 1'b1;      end
            4'd13: begin exp_byte = ETHERTYPE[7:0];   chk_byte = 1'b1;      end
            default: ;
        endcase
    end

    assign byte_bad = chk_byte && (rx_data != exp_byte);

    // lanes above the one being written are always zero, so a flush of
    // lanes_wr already has its unused upper bytes cleared
    always_comb begin
        lanes_wr = lanes_q;
        lanes_wr[{lane, 3'b000} +: 8] = rx_data;
    end

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        err_d        = err_q;
        trunc_d      = trunc_q;
        shadow_d     = shadow_q;
        pay_cnt_d    = pay_cnt_q;
        lanes_d      = lanes_q;
        rx_dst_rdy_d = rx_en;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        word_bytes_d = word_bytes_q;
        src_mac_d    = src_mac_q;
        frame_done_d = 1'b0;
        frame_good_d = frame_good_q;
        pay_len_d    = pay_len_q;
        drop_inc     = 2'd0;
        frame_inc    = 1'b0;

        if (beat) begin
            if (rx_sof) begin
                if (state_q != IDLE) begin
                    frame_done_d = 1'b1;
                    frame_good_d = 1'b0;
                    pay_len_d    = drop_len;
                    drop_inc     = 2'd1;
                    if (state_q == DATA && lane != 2'd0) begin
                        word_out_d   = lanes_q;
                        word_valid_d = 1'b1;
                        word_bytes_d = {1'b0, lane};
                    end
                end
                hdr_cnt_d = 4'd1;
                err_d     = byte_bad;
                trunc_d   = 1'b0;
                pay_cnt_d = 11'd0;
                lanes_d   = 32'd0;
                state_d   = HEAD;
                if (rx_eof) begin
                    // runt; if it also aborted a frame both drops are counted
                    frame_done_d = 1'b1;
                    frame_good_d = 1'b0;
                    if (state_q == IDLE) pay_len_d = 11'd0;
                    drop_inc     = drop_inc + 2'd1;
                    state_d      = IDLE;
                end
            end else begin
                case (state_q)
                    HEAD: begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                        if (byte_bad) err_d = 1'b1;
                        if (hdr_cnt_q >= 4'd6 && hdr_cnt_q <= 4'd11)
                            shadow_d = {shadow_q[39:0], rx_data};
                        if (hdr_cnt_q == 4'd13 && !(err_q || byte_bad)) begin
                            src_mac_d = shadow_q;
                            if (rx_eof) begin
                                frame_done_d = 1'b1;
                                frame_good_d = 1'b1;
                                pay_len_d    = 11'd0;
                                frame_inc    = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                state_d = DATA;
                            end
                        end else if (rx_eof) begin
                            frame_done_d = 1'b1;
                            frame_good_d = 1'b0;
                            pay_len_d    = 11'd0;
                            drop_inc     = 2'd1;
                            state_d      = IDLE;
                        end else if (hdr_cnt_q == 4'd13) begin
                            state_d = DROP;
                        end
                    end
                    DATA: begin
                        lanes_d   = lanes_wr;
                        pay_cnt_d = pay_next;
                        if (lane == 2'd3 || rx_eof || pay_next == MAX_LEN) begin
                            word_out_d   = lanes_wr;
                            word_valid_d = 1'b1;
                            word_bytes_d = {1'b0, lane} + 3'd1;
                            lanes_d      = 32'd0;
                        end
                        if (rx_eof) begin
                            frame_done_d = 1'b1;
                            frame_good_d = 1'b1;
                            pay_len_d    = pay_next;
                            frame_inc    = 1'b1;
                            state_d      = IDLE;
                        end else if (pay_next == MAX_LEN) begin
                            trunc_d = 1'b1;
                            state_d = DROP;
                        end
                    end
                    DROP: begin
                        if (rx_eof) begin
                            frame_done_d = 1'b1;
                            frame_good_d = 1'b0;
                            pay_len_d    = drop_len;
                            drop_inc     = 2'd1;
                            state_d      = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        frame_cnt_d = (frame_inc && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        drop_sum    = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
        drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_cnt_q    <= 4'd0;
            err_q        <= 1'b0;
            trunc_q      <= 1'b0;
            shadow_q     <= 48'd0;
            pay_cnt_q    <= 11'd0;
            lanes_q      <= 32'd0;
            rx_dst_rdy_q <= 1'b0;
            word_out_q   <= 32'd0;
            word_valid_q <= 1'b0;
            word_bytes_q <= 3'd0;
            src_mac_q    <= 48'd0;
            frame_done_q <= 1'b0;
            frame_good_q <= 1'b0;
            pay_len_q    <= 11'd0;
            frame_cnt_q  <= 16'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            hdr_cnt_q    <= hdr_cnt_d;
            err_q        <= err_d;
            trunc_q      <= trunc_d;
            shadow_q     <= shadow_d;
            pay_cnt_q    <= pay_cnt_d;
            lanes_q      <= lanes_d;
            rx_dst_rdy_q <= rx_dst_rdy_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_bytes_q <= word_bytes_d;
            src_mac_q    <= src_mac_d;
            frame_done_q <= frame_done_d;
            frame_good_q <= frame_good_d;
            pay_len_q    <= pay_len_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign rx_dst_rdy = rx_dst_rdy_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_bytes = word_bytes_q;
    assign src_mac    = src_mac_q;
    assign frame_done = frame_done_q;
    assign frame_good = frame_good_q;
    assign pay_len    = pay_len_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
